// File: rtl/tnn_feature_framer.sv
// ----------------------------------------------------------------------------
// tnn_feature_framer
//   Input framing stage for the six-feature, 2-bit TNN classifiers. Raw
//   samples arrive one per beat and are quantized to 2 bits against three
//   per-feature thresholds. Six quantized values form one frame. The frame is
//   presented on registered feat_a..feat_f buses, which feed the combinational
//   classifier directly. A second buffer lets the next frame be assembled while
//   the current one waits on downstream backpressure.
//
// Ports
//   clk, rst        sole clock; synchronous active-high reset
//   thr             18*W thresholds, feature k / threshold j at (3k+j)*W
//   s_valid/s_ready/s_data/s_last   raw sample stream
//   m_valid/m_ready                 frame handshake for feat_a..feat_f
//   feat_a..feat_f  quantized features, stable while m_valid && !m_ready
//   err_frame       one-cycle pulse on an early or missing s_last
//   frame_cnt       delivered frames, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module tnn_feature_framer #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [18*W-1:0] thr,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [1:0]      feat_a,
  output logic [1:0]      feat_b,
  output logic [1:0]      feat_c,
  output logic [1:0]      feat_d,
  output logic [1:0]      feat_e,
  output logic [1:0]      feat_f,
  output logic            err_frame,
  output logic [15:0]     frame_cnt
);

  logic [2:0]   r_idx;
  logic [1:0]   r_slot [0:5];   // slot 5 is only used by a pending frame
  logic [1:0]   r_feat [0:5];
  logic         r_pend;
  logic         r_m_valid;
  logic         r_err;
  logic [15:0]  r_cnt;

  logic [W-1:0] w_thr [0:5][0:2];
  logic [W-1:0] w_t   [0:2];
  logic [1:0]   w_q;
  logic         w_acc;
  logic         w_out_free;
  logic         w_hs;

  for (genvar k = 0; k < 6; k++) begin : g_thr_k
    for (genvar j = 0; j < 3; j++) begin : g_thr_j
      assign w_thr[k][j] = thr[(3*k+j)*W +: W];
    end
  end

  // Thresholds of the feature addressed by the current slot index.
  always_comb begin
    w_t = '{default: '0};
    for (int k = 0; k < 6; k++) begin
      if (r_idx == 3'(k)) w_t = w_thr[k];
    end
  end

  // Count of thresholds met; non-monotonic thresholds simply count as-is.
  assign w_q = {1'b0, (s_data >= w_t[0])}
             + {1'b0, (s_data >= w_t[1])}
             + {1'b0, (s_data >= w_t[2])};

  assign s_ready    = !rst && !r_pend;
  assign w_acc      = s_valid && s_ready;
  assign w_out_free = !r_m_valid || m_ready;
  assign w_hs       = r_m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_pend    <= 1'b0;
      r_m_valid <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      for (int k = 0; k < 6; k++) begin
        r_slot[k] <= '0;
        r_feat[k] <= '0;
      end
    end else begin
      r_err <= 1'b0;

      // A frame loaded below overrides this clear in the same cycle.
      if (w_hs) begin
        r_m_valid <= 1'b0;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end

      if (r_pend) begin
        if (w_out_free) begin
          for (int k = 0; k < 6; k++) r_feat[k] <= r_slot[k];
          r_m_valid <= 1'b1;
          r_pend    <= 1'b0;
        end
      end else if (w_acc) begin
        if (r_idx == 3'd5) begin
          // Frame is complete; a missing s_last is flagged but not dropped.
          r_idx <= '0;
          r_err <= !s_last;
          if (w_out_free) begin
            for (int k = 0; k < 5; k++) r_feat[k] <= r_slot[k];
            r_feat[5] <= w_q;
            r_m_valid <= 1'b1;
          end else begin
            r_slot[5] <= w_q;
            r_pend    <= 1'b1;
          end
        end else if (s_last) begin
          // Early last: the partial frame is abandoned.
          r_idx <= '0;
          r_err <= 1'b1;
        end else begin
          for (int k = 0; k < 5; k++) begin
            if (r_idx == 3'(k)) r_slot[k] <= w_q;
          end
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign feat_a    = r_feat[0];
  assign feat_b    = r_feat[1];
  assign feat_c    = r_feat[2];
  assign feat_d    = r_feat[3];
  assign feat_e    = r_feat[4];
  assign feat_f    = r_feat[5];
  assign err_frame = r_err;
  assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Testbench for tnn_feature_framer: directed scenarios plus randomized traffic,
// all checked against a queue-based frame model.
module tb_tnn_feature_framer;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [18*W-1:0] thr;
  logic            s_valid;
  logic            s_ready;
  logic [W-1:0]    s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [1:0]      feat_a, feat_b, feat_c, feat_d, feat_e, feat_f;
  logic            err_frame;
  logic [15:0]     frame_cnt;

  tnn_feature_framer #(.W(W)) dut (
    .clk(clk), .rst(rst), .thr(thr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .feat_a(feat_a), .feat_b(feat_b), .feat_c(feat_c),
    .feat_d(feat_d), .feat_e(feat_e), .feat_f(feat_f),
    .err_frame(err_frame), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Thresholds as a table; thr is packed from it.
  logic [7:0] t_arr [6][3];

  task automatic set_thr_all(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
    for (int k = 0; k < 6; k++) begin
      t_arr[k][0] = t0; t_arr[k][1] = t1; t_arr[k][2] = t2;
    end
  endtask

  task automatic pack_thr();
    logic [18*W-1:0] v;
    v = '0;
    for (int k = 5; k >= 0; k--)
      for (int j = 2; j >= 0; j--)
        v = (v << 8) | (18*W)'(t_arr[k][j]);
    thr = v;
  endtask

  // Reference model: frames as lists of quantized values.
  int         mdl_part[$];
  int         mdl_pframe[$];
  int         mdl_out[6];
  bit         mdl_pend;
  bit         mdl_valid;
  bit         mdl_err;
  int         mdl_cnt;

  function automatic int quant(input int k, input int x);
    int c = 0;
    for (int j = 0; j < 3; j++) if (x >= int'(t_arr[k][j])) c++;
    return c;
  endfunction

  function automatic logic [11:0] pack_exp();
    logic [11:0] v = '0;
    for (int k = 0; k < 6; k++) v = (v << 2) | 12'(mdl_out[k]);
    return v;
  endfunction

  function automatic logic [11:0] pack_obs();
    return {feat_a, feat_b, feat_c, feat_d, feat_e, feat_f};
  endfunction

  // One clock cycle: drive inputs, check s_ready, advance model, check outputs.
  task automatic step(input bit r, input bit sv, input logic [7:0] d, input bit sl,
                      input bit mr, output bit acc);
    bit free, exp_rdy;
    int q;
    rst = r; s_valid = sv; s_data = d; s_last = sl; m_ready = mr;
    pack_thr();
    #1;
    exp_rdy = !r && !mdl_pend;
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    acc = sv && exp_rdy;
    if (r) begin
      mdl_part.delete(); mdl_pframe.delete();
      mdl_pend = 0; mdl_valid = 0; mdl_err = 0; mdl_cnt = 0;
      for (int k = 0; k < 6; k++) mdl_out[k] = 0;
    end else begin
      free = !mdl_valid || mr;
      mdl_err = 0;
      if (mdl_valid && mr) begin
        mdl_valid = 0;
        if (mdl_cnt < 65535) mdl_cnt++;
      end
      if (mdl_pend) begin
        if (free) begin
          for (int k = 0; k < 6; k++) mdl_out[k] = mdl_pframe[k];
          mdl_valid = 1; mdl_pend = 0; mdl_pframe.delete();
        end
      end else if (acc) begin
        q = quant(mdl_part.size(), int'(d));
        if (mdl_part.size() == 5) begin
          mdl_part.push_back(q);
          mdl_err = !sl;
          if (free) begin
            for (int k = 0; k < 6; k++) mdl_out[k] = mdl_part[k];
            mdl_valid = 1;
          end else begin
            mdl_pframe = mdl_part;
            mdl_pend = 1;
          end
          mdl_part.delete();
        end else if (sl) begin
          mdl_part.delete();
          mdl_err = 1;
        end else begin
          mdl_part.push_back(q);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("m_valid", 32'(m_valid), 32'(mdl_valid));
    chk("feat", 32'(pack_obs()), 32'(pack_exp()));
    chk("err_frame", 32'(err_frame), 32'(mdl_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(mdl_cnt));
  endtask

  task automatic send_beat(input logic [7:0] d, input bit sl, input bit mr);
    bit acc = 0;
    for (int n = 0; n < 40 && !acc; n++) step(0, 1, d, sl, mr, acc);
    chk("beat_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] d [6], input bit mr);
    for (int i = 0; i < 6; i++) send_beat(d[i], i == 5, mr);
  endtask

  task automatic idle(input int n, input bit mr);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, mr, acc);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1, $urandom_range(0, 1), 8'($urandom), 0, $urandom_range(0, 1), acc);
  endtask

  logic [7:0] fr_basic [6] = '{8'd10, 8'd64, 8'd130, 8'd200, 8'd255, 8'd0};
  logic [7:0] fr_one   [6] = '{8'd0, 8'd70, 8'd140, 8'd210, 8'd0, 8'd70};
  logic [7:0] fr_two   [6] = '{8'd255, 8'd200, 8'd130, 8'd65, 8'd10, 8'd255};
  logic [7:0] fr_three [6] = '{8'd63, 8'd127, 8'd191, 8'd192, 8'd128, 8'd64};

  initial begin
    bit          acc;
    bit          sl;
    int          rises[$];
    logic [11:0] snap;

    set_thr_all(8'd64, 8'd128, 8'd192);
    rst = 1; s_valid = 0; s_data = '0; s_last = 0; m_ready = 0;
    pack_thr();

    // Reset state
    do_reset(3);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_feat", 32'(pack_obs()), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);

    // Basic frame
    send_frame(fr_basic, 1);
    chk("basic_m_valid", 32'(m_valid), 32'd1);
    chk("basic_feat", 32'(pack_obs()), 32'({2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0}));
    chk("basic_err", 32'(err_frame), 32'd0);
    idle(1, 1);
    chk("basic_cnt", 32'(frame_cnt), 32'd1);
    idle(2, 1);

    // Backpressure: frame 1 to output, frame 2 pending, frame 3 stalls
    send_frame(fr_one, 0);
    snap = pack_obs();
    chk("bp_f1", 32'(snap), 32'({2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1}));
    send_frame(fr_two, 0);
    for (int i = 0; i < 5; i++) step(0, 1, fr_three[0], 0, 0, acc);
    chk("bp_stall_rdy", 32'(s_ready), 32'd0);
    chk("bp_stable", 32'(pack_obs()), 32'(snap));
    step(0, 1, fr_three[0], 0, 1, acc);
    chk("bp_f2", 32'(pack_obs()), 32'({2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3}));
    chk("bp_rdy_back", 32'(s_ready), 32'd1);
    send_frame(fr_three, 0);
    idle(4, 1);

    // Early last on beat 3, then a correct frame
    send_beat(8'd100, 0, 1);
    send_beat(8'd100, 0, 1);
    send_beat(8'd100, 1, 1);
    chk("early_err", 32'(err_frame), 32'd1);
    chk("early_no_valid", 32'(m_valid), 32'd0);
    send_frame(fr_one, 1);
    chk("early_next_feat", 32'(pack_obs()), 32'({2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1}));
    idle(2, 1);

    // Missing last
    for (int i = 0; i < 6; i++) send_beat(fr_two[i], 0, 1);
    chk("miss_err", 32'(err_frame), 32'd1);
    chk("miss_valid", 32'(m_valid), 32'd1);
    idle(2, 1);

    // Reset with a frame pending, then with a partial frame
    send_frame(fr_one, 0);
    send_frame(fr_two, 0);
    do_reset(1);
    chk("rstmid_feat", 32'(pack_obs()), 32'd0);
    chk("rstmid_cnt", 32'(frame_cnt), 32'd0);
    chk("rstmid_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 3; i++) send_beat(8'd255, 0, 1);
    do_reset(1);
    send_frame(fr_one, 1);
    chk("rstmid_post", 32'(pack_obs()), 32'({2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1}));
    idle(1, 1);
    do_reset(1);

    // Back-to-back, 12 beats with s_valid held high
    for (int i = 0; i < 12; i++) begin
      step(0, 1, (i < 6) ? fr_basic[i] : fr_two[i-6], (i % 6) == 5, 1, acc);
      chk("b2b_acc", 32'(acc), 32'd1);
      if (m_valid) rises.push_back(i);
    end
    idle(1, 1);
    chk("b2b_frames", 32'(rises.size()), 32'd2);
    if (rises.size() == 2) chk("b2b_gap", 32'(rises[1] - rises[0]), 32'd6);
    chk("b2b_cnt", 32'(frame_cnt), 32'd2);

    // Randomized traffic with occasional threshold changes and resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0)
        for (int k = 0; k < 6; k++)
          for (int j = 0; j < 3; j++) t_arr[k][j] = 8'($urandom);
      if (mdl_part.size() == 5) sl = ($urandom_range(0, 9) != 0);
      else                      sl = ($urandom_range(0, 24) == 0);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 8'($urandom), sl,
           $urandom_range(0, 2) != 0, acc);
    end
    idle(3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
